// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART echo buffer and its FIFO.
//   - Transmit FSM state encodings (IDLE, START, WAIT_DONE, GAP)
//   - Default FIFO depth and the drop counter width
//   - sat_inc(): saturating increment for the drop counter
package uart_pkg;

    // Plain 2-bit constants rather than an enum, so netlists and
    // logic-analyzer decodes stay stable across tool versions.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int DROP_COUNT_W       = 8;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [DROP_COUNT_W-1:0] sat_inc(input logic [DROP_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read.
//   clk, reset_n : clock and asynchronous active-low reset
//   push, wdata  : write request and data. Ignored when full unless a pop
//                  happens on the same edge.
//   pop          : removes the head entry. Ignored when empty.
//   rdata        : head entry. Valid whenever empty is low.
//   full, empty  : occupancy flags
//   level        : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = uart_pkg::DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // When full, a simultaneous pop frees the slot being written. The head
    // is read from the old contents on the same edge, so nothing collides.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: the storage array has no reset. Only the pointers and the level
    // define which entries are valid, and leaving the array unreset lets it
    // map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values from before the edge. This is what makes
    // a push and a pop on the same edge resolve cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: queues every byte completed by uart_rx and sends it
// back unchanged through uart_tx's start/busy handshake.
//   clk, reset_n  : 24 MHz clock, asynchronous active-low reset
//   rx_done       : byte-complete level from uart_rx. Its rising edge pushes.
//   data_received : received byte, valid while rx_done is high
//   parity_error  : parity flag of the received byte
//   tx_busy       : transmitter busy, from uart_tx
//   start_tx      : transmit request, held until tx_busy is seen
//   data_to_tx    : byte being transmitted. Changes only when a byte is popped.
//   fifo_level    : current FIFO occupancy
//   overflow      : sticky flag, set when a byte arrived while the FIFO was full
//   drop_count    : saturating count of discarded bytes
// Build option: define UART_ECHO_PARITY_DROP_EN to discard bytes that carry a
// parity error instead of echoing them.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_done,
    input  logic [DATA_WIDTH-1:0]         data_received,
    input  logic                          parity_error,
    input  logic                          tx_busy,
    output logic                          start_tx,
    output logic [DATA_WIDTH-1:0]         data_to_tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [DROP_COUNT_W-1:0]       drop_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic                  rx_done_q;
    logic                  push_edge;
    logic                  push_req;
    logic                  parity_drop;
    logic                  ovf_drop;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [1:0]            state;
    logic [GAP_W-1:0]      gap_cnt;

    // One push per rx_done pulse, however long the receiver holds the level.
    assign push_edge = rx_done & ~rx_done_q;

`ifdef UART_ECHO_PARITY_DROP_EN
    assign parity_drop = push_edge & parity_error;
    assign push_req    = push_edge & ~parity_error;
`else
    // Corrupted bytes are echoed so the far end can see the corruption itself.
    logic unused_parity_error;
    assign unused_parity_error = parity_error;
    assign parity_drop = 1'b0;
    assign push_req    = push_edge;
`endif

    // Pops happen only from IDLE. When the FIFO is full, a pop on the same
    // edge makes room for the incoming byte.
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign ovf_drop = push_req & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req & ~ovf_drop),
        .pop     (pop),
        .wdata   (data_received),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_q  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            rx_done_q <= rx_done;
            if (ovf_drop) begin
                overflow <= 1'b1;
            end
            if (ovf_drop || parity_drop) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    // Transmit handshake. start_tx stays high until the transmitter reports
    // busy. The FSM then waits for busy to fall before it pops the next byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            start_tx   <= 1'b0;
            data_to_tx <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        data_to_tx <= fifo_rdata;
                        start_tx   <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_busy) begin
                        start_tx <= 1'b0;
                        state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
